// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_pkg
//  Purpose  : Shared definitions for the register-file memory controller.
//             Holds the controller state encoding and the parameter defaults
//             used by regfile_ctrl.
//  Contents : state_t          controller state encoding
//             DEF_ADR          default address width
//             DEF_DAT          default data width
//             DEF_DPTH         default number of implemented entries
//  Revision : 1.0  initial release
// ============================================================================
package regfile_pkg;

  localparam int DEF_ADR  = 8;
  localparam int DEF_DAT  = 8;
  localparam int DEF_DPTH = 8;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_ctrl
//  Purpose  : Single-outstanding request/response controller in front of a
//             single-port synchronous memory. After reset it clears entries
//             0..DPTH-1, then serves one read or write at a time. Addresses at
//             or above DPTH are answered with an error and never reach memory.
//  Ports    : Clk, Rst                      clock, sync active-high reset
//             req_valid/req_ready           request handshake
//             req_write/req_addr/req_wdata  request payload
//             rsp_valid/rsp_ready           response handshake
//             rsp_rdata/rsp_err             response payload
//             mem_cs/mem_we/mem_rd          memory strobes
//             mem_addr/mem_wdata/mem_rdata  memory address and data
//  Revision : 1.0  initial release
// ============================================================================
module regfile_ctrl
  import regfile_pkg::*;
#(
  parameter int ADR  = DEF_ADR,
  parameter int DAT  = DEF_DAT,
  parameter int DPTH = DEF_DPTH
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_write,
  input  logic [ADR-1:0] req_addr,
  input  logic [DAT-1:0] req_wdata,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [DAT-1:0] rsp_rdata,
  output logic           rsp_err,
  output logic           mem_cs,
  output logic           mem_we,
  output logic           mem_rd,
  output logic [ADR-1:0] mem_addr,
  output logic [DAT-1:0] mem_wdata,
  input  logic [DAT-1:0] mem_rdata
);

  // One extra bit so the counter can hold DPTH itself as the "sweep done" mark.
  localparam int            CW      = $clog2(DPTH) + 1;
  localparam logic [CW-1:0] CNT_END = CW'(DPTH);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_wr;
  logic          r_err;
  logic          w_in_range;

  assign w_in_range = (32'(req_addr) < 32'(DPTH));

  // All outputs are registered: strobes for a cycle are decided on the edge
  // that enters that cycle, so ISSUE's memory access is set up at accept.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state   <= ST_INIT;
      r_cnt     <= '0;
      r_wr      <= 1'b0;
      r_err     <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_cnt == CNT_END) begin
            // Last clearing write (DPTH-1) is on the bus this cycle.
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            req_ready <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            mem_cs    <= 1'b1;
            mem_we    <= 1'b1;
            mem_rd    <= 1'b0;
            mem_addr  <= ADR'(r_cnt);
            mem_wdata <= '0;
            r_cnt     <= r_cnt + 1'b1;
          end
        end

        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            r_wr      <= req_write;
            mem_addr  <= req_addr;
            mem_wdata <= req_write ? req_wdata : '0;
            if (w_in_range) begin
              mem_cs <= 1'b1;
              mem_we <= req_write;
              mem_rd <= ~req_write;
              r_err  <= 1'b0;
            end else begin
              r_err  <= 1'b1;
            end
            r_state <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          mem_cs <= 1'b0;
          mem_we <= 1'b0;
          mem_rd <= 1'b0;
          if (r_wr || r_err) begin
            rsp_valid <= 1'b1;
            rsp_err   <= r_err;
            rsp_rdata <= '0;
            r_state   <= ST_RESP;
          end else begin
            r_state   <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          // Memory registered the read on the ISSUE edge; data is valid now.
          rsp_rdata <= mem_rdata;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          r_state   <= ST_RESP;
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            req_ready <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_INIT;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule : regfile_ctrl
`default_nettype wire

// File: tb/tb_regfile_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_ctrl
//  Purpose  : Self-checking bench for regfile_ctrl with a behavioural memory
//             and an array-based reference of the expected memory contents.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_ctrl;

  localparam int ADR  = 8;
  localparam int DAT  = 8;
  localparam int DPTH = 8;

  logic           Clk = 1'b0;
  logic           Rst = 1'b1;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic           req_write = 1'b0;
  logic [ADR-1:0] req_addr = '0;
  logic [DAT-1:0] req_wdata = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [DAT-1:0] rsp_rdata;
  logic           rsp_err;
  logic           mem_cs, mem_we, mem_rd;
  logic [ADR-1:0] mem_addr;
  logic [DAT-1:0] mem_wdata;
  logic [DAT-1:0] mem_rdata;

  regfile_ctrl #(.ADR(ADR), .DAT(DAT), .DPTH(DPTH)) dut (
    .Clk(Clk), .Rst(Rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 Clk = ~Clk;

  // Behavioural single-port synchronous memory covering the full address space.
  logic [DAT-1:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = DAT'($urandom);
    mem_rdata = '0;
  end
  always @(posedge Clk) begin
    if (mem_cs && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_cs && mem_rd) mem_rdata <= mem[mem_addr];
  end

  // Event counters sampled by the tests.
  int both_cnt = 0;
  int cs_cnt   = 0;
  int rv_cnt   = 0;
  always @(posedge Clk) begin
    if (mem_we === 1'b1 && mem_rd === 1'b1) both_cnt++;
    if (mem_cs === 1'b1) cs_cnt++;
    if (rsp_valid === 1'b1) rv_cnt++;
  end

  int total = 0;
  int bad   = 0;

  // Reference memory contents as the requester should see them.
  int ref_mem [DPTH];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic ref_clear();
    for (int i = 0; i < DPTH; i++) ref_mem[i] = 0;
  endtask

  task automatic wait_ready(output bit tmo);
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin tick(); n++; end
    tmo = (req_ready !== 1'b1);
  endtask

  // Drives one transaction and reports what was observed; the callers compare.
  task automatic do_txn(input bit wr, input int addr, input int wdata, input int hold,
                        output int lat, output int rdata, output bit err,
                        output bit tmo, output bit busy_rdy, output bit stable,
                        output bit post_rdy);
    bit t0;
    wait_ready(t0);
    req_valid = 1'b1; req_write = wr; req_addr = ADR'(addr); req_wdata = DAT'(wdata);
    tick();
    req_valid = 1'b0;
    lat = 1;
    busy_rdy = (req_ready === 1'b1);
    while (rsp_valid !== 1'b1 && lat < 10) begin
      tick(); lat++;
      if (req_ready === 1'b1) busy_rdy = 1'b1;
    end
    tmo = t0 || (rsp_valid !== 1'b1);
    rdata = int'(rsp_rdata);
    err = rsp_err;
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      tick();
      if (rsp_valid !== 1'b1 || int'(rsp_rdata) != rdata || rsp_err !== err || req_ready !== 1'b0)
        stable = 1'b0;
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    post_rdy = (req_ready === 1'b1) && (rsp_valid === 1'b0);
  endtask

  task automatic test_reset();
    int waddr [$];
    bit data_ok = 1'b1;
    bit prev_a7 = 1'b0;
    bit got_rdy = 1'b0;
    Rst = 1'b1;
    tick(); tick();
    total++;
    if ({req_ready, rsp_valid, rsp_err, mem_cs, mem_we, mem_rd} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=000000",
                      {req_ready, rsp_valid, rsp_err, mem_cs, mem_we, mem_rd});
    end
    total++;
    if (rsp_rdata !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
      bad++; $display("FAIL reset_buses rdata=%h addr=%h wdata=%h want=0", rsp_rdata, mem_addr, mem_wdata);
    end
    Rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (req_ready === 1'b1) begin got_rdy = 1'b1; break; end
      prev_a7 = 1'b0;
      if (mem_cs === 1'b1) begin
        waddr.push_back(int'(mem_addr));
        if (mem_we !== 1'b1 || mem_rd !== 1'b0 || mem_wdata !== '0) data_ok = 1'b0;
        prev_a7 = (int'(mem_addr) == DPTH - 1);
      end
    end
    total++;
    if (!got_rdy) begin bad++; $display("FAIL init_ready_timeout got=0 want=1"); end
    total++;
    if (waddr.size() != DPTH) begin
      bad++; $display("FAIL init_write_count got=%0d want=%0d", waddr.size(), DPTH);
    end else begin
      bit order_ok = 1'b1;
      for (int i = 0; i < DPTH; i++) if (waddr[i] != i) order_ok = 1'b0;
      total++;
      if (!order_ok) begin bad++; $display("FAIL init_order got=%p want=ascending 0..%0d", waddr, DPTH-1); end
    end
    total++;
    if (!data_ok) begin bad++; $display("FAIL init_strobes got=bad want=we=1 rd=0 wdata=0"); end
    total++;
    if (!prev_a7) begin bad++; $display("FAIL init_ready_timing got=not_after_a7 want=after_a7"); end
    ref_clear();
  endtask

  task automatic test_write_read();
    int lat, rd; bit err, tmo, br, st, pr;
    do_txn(1'b1, 3, 8'hA5, 0, lat, rd, err, tmo, br, st, pr);
    ref_mem[3] = 8'hA5;
    total++;
    if (tmo || lat != 2 || err !== 1'b0 || rd != 0) begin
      bad++; $display("FAIL wr3 got lat=%0d err=%0b rdata=%h tmo=%0b want lat=2 err=0 rdata=00", lat, err, rd, tmo);
    end
    total++;
    if (br || !pr) begin bad++; $display("FAIL wr3_ready got busy=%0b post=%0b want busy=0 post=1", br, pr); end
    do_txn(1'b0, 3, 0, 0, lat, rd, err, tmo, br, st, pr);
    total++;
    if (tmo || lat != 3 || err !== 1'b0 || rd != 8'hA5) begin
      bad++; $display("FAIL rd3 got lat=%0d err=%0b rdata=%h want lat=3 err=0 rdata=a5", lat, err, rd);
    end
  endtask

  task automatic test_out_of_range();
    int lat, rd; bit err, tmo, br, st, pr;
    int cs0 = cs_cnt;
    do_txn(1'b0, 9, 0, 0, lat, rd, err, tmo, br, st, pr);
    total++;
    if (cs_cnt != cs0) begin bad++; $display("FAIL oob_cs got=%0d want=0", cs_cnt - cs0); end
    total++;
    if (tmo || err !== 1'b1 || rd != 0 || lat != 2) begin
      bad++; $display("FAIL oob_rd9 got lat=%0d err=%0b rdata=%h want lat=2 err=1 rdata=00", lat, err, rd);
    end
    cs0 = cs_cnt;
    do_txn(1'b1, 200, 8'h77, 0, lat, rd, err, tmo, br, st, pr);
    total++;
    if (cs_cnt != cs0 || tmo || err !== 1'b1 || rd != 0) begin
      bad++; $display("FAIL oob_wr200 got cs=%0d err=%0b rdata=%h want cs=0 err=1 rdata=00", cs_cnt - cs0, err, rd);
    end
  endtask

  task automatic test_backpressure();
    int lat, rd; bit err, tmo, br, st, pr;
    do_txn(1'b1, 5, 8'h3C, 0, lat, rd, err, tmo, br, st, pr);
    ref_mem[5] = 8'h3C;
    do_txn(1'b0, 5, 0, 4, lat, rd, err, tmo, br, st, pr);
    total++;
    if (tmo || rd != ref_mem[5] || err !== 1'b0) begin
      bad++; $display("FAIL bp_data got=%h err=%0b want=%h err=0", rd, err, ref_mem[5]);
    end
    total++;
    if (!st) begin bad++; $display("FAIL bp_stable got=unstable want=stable_4_cycles"); end
    total++;
    if (!pr) begin bad++; $display("FAIL bp_return_idle got=0 want=1"); end
  endtask

  task automatic test_reset_mid();
    int lat, rd; bit err, tmo, br, st, pr, t0;
    int rv0;
    do_txn(1'b1, 3, 8'h5A, 0, lat, rd, err, tmo, br, st, pr);
    wait_ready(t0);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd3;
    tick();               // accept edge -> ISSUE
    req_valid = 1'b0;
    tick();               // ISSUE -> WAIT
    rv0 = rv_cnt;
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    wait_ready(t0);
    total++;
    if (rv_cnt != rv0 || t0) begin
      bad++; $display("FAIL rstmid_no_rsp got rsp_cycles=%0d tmo=%0b want 0/0", rv_cnt - rv0, t0);
    end
    ref_clear();
    do_txn(1'b0, 3, 0, 0, lat, rd, err, tmo, br, st, pr);
    total++;
    if (tmo || rd != ref_mem[3] || err !== 1'b0) begin
      bad++; $display("FAIL rstmid_rd3 got=%h want=%h", rd, ref_mem[3]);
    end
  endtask

  task automatic test_random();
    int lat, rd; bit err, tmo, br, st, pr;
    int nbad0 = bad;
    int both0 = both_cnt;
    for (int n = 0; n < 1000; n++) begin
      bit wr = 1'($urandom);
      int a = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 11));
      int d = int'($urandom_range(0, 255));
      int hold = int'($urandom_range(0, 2));
      bit e_err = (a >= DPTH);
      int e_rd = (!wr && !e_err) ? ref_mem[a] : 0;
      int e_lat = (wr || e_err) ? 2 : 3;
      do_txn(wr, a, d, hold, lat, rd, err, tmo, br, st, pr);
      if (wr && !e_err) ref_mem[a] = d;
      total++;
      if (tmo || rd != e_rd || err !== e_err || lat != e_lat) begin
        bad++;
        if (bad - nbad0 < 10)
          $display("FAIL rand#%0d wr=%0b a=%0d got rdata=%h err=%0b lat=%0d want rdata=%h err=%0b lat=%0d",
                   n, wr, a, rd, err, lat, e_rd, e_err, e_lat);
      end
      total++;
      if (br || !st || !pr) begin
        bad++;
        if (bad - nbad0 < 10)
          $display("FAIL rand_hs#%0d got busy=%0b stable=%0b post=%0b want 0/1/1", n, br, st, pr);
      end
    end
    total++;
    if (both_cnt != both0) begin bad++; $display("FAIL we_rd_overlap got=%0d want=0", both_cnt - both0); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_out_of_range();
    test_backpressure();
    test_reset_mid();
    test_random();
    total++;
    if (both_cnt != 0) begin bad++; $display("FAIL we_rd_overlap_all got=%0d want=0", both_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_regfile_ctrl
`default_nettype wire

// File: doc/regfile_ctrl.md
REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 SHALL have parameter ADR, default 8, address width in bits.
REQ-002 SHALL have parameter DAT, default 8, data width in bits.
REQ-003 SHALL have parameter DPTH, default 8, number of implemented memory entries.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 Clk  input  1  rising-edge clock.
REQ-006 Rst  input  1  synchronous active-high reset.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  controller accepts request this cycle.
REQ-009 req_write  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  ADR  request address.
REQ-011 req_wdata  input  DAT  write data.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  requester consumes response.
REQ-014 rsp_rdata  output  DAT  read data; 0 for writes and errors.
REQ-015 rsp_err  output  1  address out of range.
REQ-016 mem_cs, mem_we, mem_rd  output  1 each  memory chip-select, write-enable, read-enable.
REQ-017 mem_addr  output  ADR; mem_wdata  output  DAT  memory address and write data.
REQ-018 mem_rdata  input  DAT  memory read data, valid the cycle after a read edge.

Function
REQ-019 SHALL be the initiator for a single-port synchronous memory: write on the edge with cs=1, we=1, rd=0; read data registered by memory on the edge with cs=1, rd=1, we=0.
REQ-020 SHALL never drive mem_we and mem_rd high in the same cycle.
REQ-021 SHALL implement states INIT, IDLE, ISSUE, WAIT, RESP; all outputs registered.
REQ-022 INIT: one write per cycle of 0 to addresses 0..DPTH-1 ascending; after address DPTH-1 go to IDLE; req_ready=0 throughout.
REQ-023 IDLE: req_ready=1; on req_valid&req_ready latch write/addr/wdata, go to ISSUE.
REQ-024 ISSUE (one cycle): in-range addr (< DPTH) drives cs=1 plus we or rd; out-of-range addr drives cs=0, sets error flag; write or error -> RESP, in-range read -> WAIT.
REQ-025 WAIT (one cycle): capture mem_rdata into rsp_rdata at end of cycle, go to RESP.
REQ-026 RESP: rsp_valid=1, rsp_rdata/rsp_err held stable until rsp_valid&rsp_ready, then IDLE.
REQ-027 Latency from accept edge: write response rsp_valid at cycle 2, read response at cycle 3; with rsp_ready=1 next accept possible 1 cycle after response.
REQ-028 req_ready SHALL be 0 in all states except IDLE; single outstanding transaction.
REQ-029 mem_cs/mem_we/mem_rd SHALL be 0 in IDLE, WAIT, RESP.
REQ-030 INIT address counter SHALL be ceil(log2(DPTH))+1 bits wide; no wrap past DPTH-1.

Reset
REQ-031 Rst=1 SHALL force state INIT, INIT counter 0, and req_ready, rsp_valid, rsp_err, rsp_rdata, mem_cs, mem_we, mem_rd, mem_addr, mem_wdata to 0.
REQ-032 Rst asserted mid-transaction SHALL abort it with no response and restart the INIT sweep.

Structure
REQ-033 State encodings and parameter defaults SHALL live in shared package regfile_pkg.
REQ-034 No sub-module; single module; memory instantiated only in the testbench.

Verification
REQ-035 Release reset, DPTH=8 -> 8 consecutive writes of 0 to addr 0..7, req_ready rises the cycle after addr 7.
REQ-036 Write addr 3 data 0xA5, then read addr 3 -> write rsp at cycle 2 (err=0, rdata=0); read rsp at cycle 3, rdata=0xA5.
REQ-037 Read addr 9 (DPTH=8) -> mem_cs never asserted, rsp_err=1, rsp_rdata=0.
REQ-038 Read addr 5 with rsp_ready=0 for 4 cycles -> rsp_valid and rdata stable 4 cycles, req_ready=0, then IDLE.
REQ-039 Rst pulsed during WAIT -> no rsp_valid, INIT sweep reruns, prior data in addr 3 reads back 0.
REQ-040 Random request stream, 1000 transactions, against scoreboard -> all read data match, we&rd never both 1.
